input_conditioner: RTL

INPUT_CONDITIONER -- requirements
Module: input_conditioner

---
 rtl/input_conditioner_pkg.sv | 28 ++
 rtl/input_conditioner_debounce_cell.sv | 99 +++++++++
 rtl/input_conditioner.sv | 54 +++++
 3 files changed

// File: rtl/input_conditioner_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : input_conditioner_pkg
//  Description : Parameter defaults, legal ranges and the debounce counter
//                width helper. The SoC top and the conditioner share these.
//  Revision    : 1.0  initial release
// ============================================================================
package input_conditioner_pkg;

  // Parameter defaults
  localparam int unsigned c_width_default           = 4;
  localparam int unsigned c_sync_stages_default     = 2;
  localparam int unsigned c_debounce_cycles_default = 16;

  // Legal parameter ranges
  localparam int unsigned c_sync_stages_min     = 2;
  localparam int unsigned c_sync_stages_max     = 4;
  localparam int unsigned c_debounce_cycles_min = 1;

  // Counter width: max(1, clog2(cycles)). A count of 0..cycles-1 always fits.
  function automatic int unsigned ic_cnt_width(input int unsigned cycles);
    int unsigned w;
    w = $clog2(cycles);
    return (w < 1) ? 1 : w;
  endfunction

endpackage : input_conditioner_pkg
`default_nettype wire

// File: rtl/input_conditioner_debounce_cell.sv
`default_nettype none
// ============================================================================
//  Module      : debounce_cell
//  Description : One input channel: synchronizer chain, debounce counter,
//                accepted level, qualified edge strobe and sticky pending flag.
//  Revision    : 1.0  initial release
// ============================================================================
module debounce_cell
  import input_conditioner_pkg::*;
#(
  parameter int unsigned SYNC_STAGES     = c_sync_stages_default,
  parameter int unsigned DEBOUNCE_CYCLES = c_debounce_cycles_default,
  parameter int unsigned CNT_W           = ic_cnt_width(DEBOUNCE_CYCLES)
) (
  input  logic clk,
  input  logic reset,
  input  logic din,
  input  logic rise_en,
  input  logic fall_en,
  input  logic irq_clr,
  output logic level,
  output logic edge_pulse,
  output logic irq_pending
);

  localparam logic [CNT_W-1:0] c_cnt_max  = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] c_cnt_zero = '0;
  localparam logic [CNT_W-1:0] c_cnt_one  = CNT_W'(1);

  logic [SYNC_STAGES-1:0] r_sync;
  logic [CNT_W-1:0]       r_cnt;
  logic                   r_level;
  logic                   r_evt;
  logic                   r_edge;
  logic                   r_pending;

  logic w_sync;
  logic w_differs;
  logic w_accept;
  logic w_evt;

  assign w_sync    = r_sync[SYNC_STAGES-1];
  assign w_differs = (w_sync != r_level);
  assign w_accept  = w_differs && (r_cnt == c_cnt_max);
  // The enable is chosen by the new level and sampled only on the accepting cycle.
  assign w_evt     = w_accept && (w_sync ? rise_en : fall_en);

  // Synchronizer chain: din enters at bit 0, the oldest sample is the sync output.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_sync <= '0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], din};
    end
  end

  // Debounce: count consecutive differing cycles, accept on the last one, saturate-free.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt   <= c_cnt_zero;
      r_level <= 1'b0;
    end else if (w_accept) begin
      r_cnt   <= c_cnt_zero;
      r_level <= w_sync;
    end else if (w_differs) begin
      r_cnt   <= r_cnt + c_cnt_one;
    end else begin
      r_cnt   <= c_cnt_zero;
    end
  end

  // Event capture on acceptance, then the strobe one cycle after level moves.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_evt  <= 1'b0;
      r_edge <= 1'b0;
    end else begin
      r_evt  <= w_evt;
      r_edge <= r_evt;
    end
  end

  // Sticky pending: a new event beats a coincident clear.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_pending <= 1'b0;
    end else if (r_evt) begin
      r_pending <= 1'b1;
    end else if (irq_clr) begin
      r_pending <= 1'b0;
    end
  end

  assign level       = r_level;
  assign edge_pulse  = r_edge;
  assign irq_pending = r_pending;

endmodule : debounce_cell
`default_nettype wire

// File: rtl/input_conditioner.sv
`default_nettype none
// ============================================================================
//  Module      : input_conditioner
//  Description : WIDTH independent pushbutton/switch conditioners with
//                synchronization, debounce, qualified edge events, sticky
//                pending flags and a combined interrupt line.
//                Legal ranges: SYNC_STAGES 2..4, DEBOUNCE_CYCLES >= 1.
//  Revision    : 1.0  initial release
// ============================================================================
module input_conditioner
  import input_conditioner_pkg::*;
#(
  parameter int unsigned WIDTH           = c_width_default,
  parameter int unsigned SYNC_STAGES     = c_sync_stages_default,
  parameter int unsigned DEBOUNCE_CYCLES = c_debounce_cycles_default
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] din,
  input  logic [WIDTH-1:0] rise_en,
  input  logic [WIDTH-1:0] fall_en,
  input  logic [WIDTH-1:0] irq_clr,
  output logic [WIDTH-1:0] level,
  output logic [WIDTH-1:0] edge_pulse,
  output logic [WIDTH-1:0] irq_pending,
  output logic             irq
);

  localparam int unsigned CNT_W = ic_cnt_width(DEBOUNCE_CYCLES);

  // One self-contained cell per channel; channels share nothing but clock and reset.
  for (genvar i = 0; i < WIDTH; i++) begin : g_ch
    debounce_cell #(
      .SYNC_STAGES     (SYNC_STAGES),
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .CNT_W           (CNT_W)
    ) u_cell (
      .clk         (clk),
      .reset       (reset),
      .din         (din[i]),
      .rise_en     (rise_en[i]),
      .fall_en     (fall_en[i]),
      .irq_clr     (irq_clr[i]),
      .level       (level[i]),
      .edge_pulse  (edge_pulse[i]),
      .irq_pending (irq_pending[i])
    );
  end : g_ch

  // Interrupt is a plain OR so it follows pending flags with no added latency.
  assign irq = |irq_pending;

endmodule : input_conditioner
`default_nettype wire
